control_decoder: RTL and testbench

Control decoder at the consuming end of the sequencer's step interface. It samples the 6-bit step code (`smInput`) each clock and produces the registered datapath control word. It owns the instruction register that returns `IROut` to the sequencer and the Z flag register that returns `z_in`. It sits between the sequencer and the datapath/memory and also holds the sticky halt state.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/step_rom.sv | 11 +
 rtl/control_decoder.sv | 140 ++++++++++++++
 tb/tb_control_decoder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: step codes, the datapath control word and the step ROM
// that maps each 6-bit step code to its control word.
package cpu_pkg;

    localparam logic [5:0] STEP_FETCH1 = 6'd1;
    localparam logic [5:0] STEP_FETCH2 = 6'd2;
    localparam logic [5:0] STEP_FETCH3 = 6'd3;
    localparam logic [5:0] STEP_EXEC1  = 6'd4;
    localparam logic [5:0] STEP_EXEC2  = 6'd5;
    localparam logic [5:0] STEP_EXEC3  = 6'd6;
    localparam logic [5:0] STEP_EXEC4  = 6'd7;
    localparam logic [5:0] STEP_ALU0   = 6'd36;
    localparam logic [5:0] STEP_ALU15  = 6'd51;
    localparam logic [5:0] STEP_NOP    = 6'd56;
    localparam logic [5:0] STEP_HALT   = 6'd57;

    typedef struct packed {
        logic [3:0] bus_sel;
        logic [7:0] reg_we;
        logic [2:0] alu_op;
        logic       alu_en;
        logic       mem_rd;
        logic       mem_wr;
        logic       pc_inc;
        logic       ir_load;
    } cw_t;

    localparam cw_t CW_NOP = '0;

    typedef cw_t [63:0] rom_t;

    // Every code not set here, including NOP and HALT, stays at the all-zero word.
    function automatic rom_t build_rom();
        rom_t r;
        r = '0;
        r[STEP_FETCH1].bus_sel = 4'd1;
        r[STEP_FETCH1].reg_we  = 8'h01;
        r[STEP_FETCH1].mem_rd  = 1'b1;
        r[STEP_FETCH2].mem_rd  = 1'b1;
        r[STEP_FETCH2].pc_inc  = 1'b1;
        r[STEP_FETCH3].ir_load = 1'b1;
        for (int s = 36; s <= 51; s++) begin
            r[s].alu_en = 1'b1;
            r[s].alu_op = 3'(s - 36);
        end
        return r;
    endfunction

    localparam rom_t STEP_ROM = build_rom();

endpackage

// File: rtl/step_rom.sv
// Combinational step code to control word lookup, shared with the sequencer bench.
module step_rom
    import cpu_pkg::*;
(
    input  logic [5:0] i_step,
    output cw_t        o_cw
);

    assign o_cw = STEP_ROM[i_step];

endmodule

// File: rtl/control_decoder.sv
// Control decoder: registered control word, instruction register, Z flag and sticky halt.
// Optional STEP_CHECK_EN macro adds a sticky step-order checker driving step_err.
module control_decoder
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        smInput,
    input  logic [5:0]        IRIn,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] alu_result,
    output logic [5:0]        IROut,
    output logic              z_out,
    output logic [3:0]        bus_sel,
    output logic [7:0]        reg_we,
    output logic [2:0]        alu_op,
    output logic              alu_en,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              pc_inc,
    output logic              halted,
    output logic              step_err
);

    cw_t  w_cw;
    logic w_en;

    logic [3:0] r_bus_sel;
    logic [7:0] r_reg_we;
    logic [2:0] r_alu_op;
    logic       r_alu_en;
    logic       r_mem_rd;
    logic       r_mem_wr;
    logic       r_pc_inc;
    logic [5:0] r_ir;
    logic [5:0] r_irin_q;
    logic       r_z;
    logic       r_halted;

    step_rom u_step_rom (
        .i_step (smInput),
        .o_cw   (w_cw)
    );

    assign w_en = start && !r_halted;

    // The HALT entry of the ROM is the NOP word, so the halting edge already outputs NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_sel <= '0;
            r_reg_we  <= '0;
            r_alu_op  <= '0;
            r_alu_en  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_pc_inc  <= 1'b0;
            r_ir      <= STEP_FETCH1;
            r_irin_q  <= 6'd1;
            r_z       <= 1'b0;
            r_halted  <= 1'b0;
        end else if (w_en) begin
            r_bus_sel <= w_cw.bus_sel;
            r_reg_we  <= w_cw.reg_we;
            r_alu_op  <= w_cw.alu_op;
            r_alu_en  <= w_cw.alu_en;
            r_mem_rd  <= w_cw.mem_rd;
            r_mem_wr  <= w_cw.mem_wr;
            r_pc_inc  <= w_cw.pc_inc;
            if (w_cw.ir_load) begin
                r_ir <= mem_rdata[5:0];
            end else if (IRIn != r_irin_q) begin
                r_ir <= IRIn;
            end
            r_irin_q <= IRIn;
            if (w_cw.alu_en) begin
                r_z <= (alu_result == '0);
            end
            if (smInput == STEP_HALT) begin
                r_halted <= 1'b1;
            end
        end else begin
            r_bus_sel <= '0;
            r_reg_we  <= '0;
            r_alu_op  <= '0;
            r_alu_en  <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_pc_inc  <= 1'b0;
        end
    end

`ifdef STEP_CHECK_EN
    logic [5:0] r_prev;
    logic       r_err;
    logic       w_bad;

    always_comb begin
        w_bad = 1'b0;
        case (smInput)
            STEP_FETCH2: w_bad = (r_prev != STEP_FETCH1);
            STEP_FETCH3: w_bad = (r_prev != STEP_FETCH2);
            STEP_EXEC2:  w_bad = (r_prev != STEP_EXEC1);
            STEP_EXEC3:  w_bad = (r_prev != STEP_EXEC2);
            STEP_EXEC4:  w_bad = (r_prev != STEP_EXEC3);
            default:     w_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
            r_err  <= 1'b0;
        end else if (w_en) begin
            r_prev <= smInput;
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign step_err = r_err;
`else
    assign step_err = 1'b0;
`endif

    assign bus_sel = r_bus_sel;
    assign reg_we  = r_reg_we;
    assign alu_op  = r_alu_op;
    assign alu_en  = r_alu_en;
    assign mem_rd  = r_mem_rd;
    assign mem_wr  = r_mem_wr;
    assign pc_inc  = r_pc_inc;
    assign IROut   = r_ir;
    assign z_out   = r_z;
    assign halted  = r_halted;

endmodule

// File: tb/tb_control_decoder.sv
// Bench for control_decoder: a vector table of directed sequences plus a random ALU-step
// sweep, with expected results queued at drive time and popped after each edge.
module tb_control_decoder;

`ifdef STEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // ctrl packing: {bus_sel[3:0], reg_we[7:0], alu_op[2:0], alu_en, mem_rd, mem_wr, pc_inc}
    localparam logic [18:0] C_NOP = 19'd0;
    localparam logic [18:0] C_F1  = {4'd1, 8'h01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [18:0] C_F2  = {4'd0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct {
        logic        rst;
        logic        start;
        logic [5:0]  sm;
        logic [5:0]  irin;
        logic [15:0] mem;
        logic [15:0] alu;
        logic [18:0] ctrl;
        logic [5:0]  iro;
        logic        z;
        logic        halt;
        logic        err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  smInput;
    logic [5:0]  IRIn;
    logic [15:0] mem_rdata;
    logic [15:0] alu_result;
    logic [5:0]  IROut;
    logic        z_out;
    logic [3:0]  bus_sel;
    logic [7:0]  reg_we;
    logic [2:0]  alu_op;
    logic        alu_en;
    logic        mem_rd;
    logic        mem_wr;
    logic        pc_inc;
    logic        halted;
    logic        step_err;

    logic [27:0] exp_q[$];
    vec_t        vt[$];
    int          n_checks;
    int          n_fail;

    control_decoder #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .smInput    (smInput),
        .IRIn       (IRIn),
        .mem_rdata  (mem_rdata),
        .alu_result (alu_result),
        .IROut      (IROut),
        .z_out      (z_out),
        .bus_sel    (bus_sel),
        .reg_we     (reg_we),
        .alu_op     (alu_op),
        .alu_en     (alu_en),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .pc_inc     (pc_inc),
        .halted     (halted),
        .step_err   (step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] c_alu(input logic [2:0] op);
        return {4'd0, 8'd0, op, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction

    function automatic vec_t v(input logic r, input logic st, input logic [5:0] sm,
                               input logic [5:0] irin, input logic [15:0] mem,
                               input logic [15:0] alu, input logic [18:0] ctrl,
                               input logic [5:0] iro, input logic z, input logic h,
                               input logic e);
        vec_t x;
        x.rst = r; x.start = st; x.sm = sm; x.irin = irin; x.mem = mem; x.alu = alu;
        x.ctrl = ctrl; x.iro = iro; x.z = z; x.halt = h; x.err = e;
        return x;
    endfunction

    task automatic cmp(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_out();
        logic [27:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: expected queue empty");
            return;
        end
        e = exp_q.pop_front();
        cmp("ctrl",     {bus_sel, reg_we, alu_op, alu_en, mem_rd, mem_wr, pc_inc}, e[27:9]);
        cmp("IROut",    19'(IROut),    19'(e[8:3]));
        cmp("z_out",    19'(z_out),    19'(e[2]));
        cmp("halted",   19'(halted),   19'(e[1]));
        cmp("step_err", 19'(step_err), 19'(e[0]));
    endtask

    task automatic apply(input vec_t x);
        @(negedge clk);
        rst        = x.rst;
        start      = x.start;
        smInput    = x.sm;
        IRIn       = x.irin;
        mem_rdata  = x.mem;
        alu_result = x.alu;
        exp_q.push_back({x.ctrl, x.iro, x.z, x.halt, x.err & CHK});
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        smInput    = 6'd0;
        IRIn       = 6'd1;
        mem_rdata  = 16'hFFFF;
        alu_result = 16'hFFFF;

        // rst start sm irin mem alu ctrl iro z halt err
        vt.push_back(v(1, 1,  0, 1, 16'hFFFF, 16'hFFFF, C_NOP,      1, 0, 0, 0)); // reset
        vt.push_back(v(0, 1,  1, 1, 16'hFFFF, 16'hFFFF, C_F1,       1, 0, 0, 0)); // fetch1
        vt.push_back(v(0, 1,  2, 1, 16'hFFFF, 16'hFFFF, C_F2,       1, 0, 0, 0)); // fetch2
        vt.push_back(v(0, 1,  3, 1, 16'h0004, 16'hFFFF, C_NOP,      4, 0, 0, 0)); // ir_load
        vt.push_back(v(0, 1, 40, 1, 16'hFFFF, 16'h0000, c_alu(3'd4), 4, 1, 0, 0)); // z set
        vt.push_back(v(0, 1, 40, 1, 16'hFFFF, 16'h0005, c_alu(3'd4), 4, 0, 0, 0)); // z clear
        vt.push_back(v(0, 1, 56, 1, 16'hFFFF, 16'h0000, C_NOP,      4, 0, 0, 0)); // nop holds z
        vt.push_back(v(0, 0, 40, 1, 16'hFFFF, 16'h0000, C_NOP,      4, 0, 0, 0)); // start low
        vt.push_back(v(0, 1,  3, 8, 16'h000C, 16'hFFFF, C_NOP,     12, 0, 0, 1)); // ir_load beats IRIn
        vt.push_back(v(0, 1,  0, 8, 16'hFFFF, 16'hFFFF, C_NOP,     12, 0, 0, 1)); // IRIn consumed
        vt.push_back(v(0, 1,  1, 9, 16'hFFFF, 16'hFFFF, C_F1,       9, 0, 0, 1)); // IRIn change
        vt.push_back(v(0, 1, 57, 9, 16'hFFFF, 16'hFFFF, C_NOP,      9, 0, 1, 1)); // halt
        vt.push_back(v(0, 1,  1, 20, 16'hFFFF, 16'hFFFF, C_NOP,     9, 0, 1, 1)); // halted frozen
        vt.push_back(v(0, 1, 40, 20, 16'hFFFF, 16'h0000, C_NOP,     9, 0, 1, 1)); // halted frozen
        vt.push_back(v(1, 1,  0, 1, 16'hFFFF, 16'hFFFF, C_NOP,      1, 0, 0, 0)); // reset clears
        vt.push_back(v(0, 1,  1, 1, 16'hFFFF, 16'hFFFF, C_F1,       1, 0, 0, 0)); // clean 1..7
        vt.push_back(v(0, 1,  2, 1, 16'hFFFF, 16'hFFFF, C_F2,       1, 0, 0, 0));
        vt.push_back(v(0, 1,  3, 1, 16'h0007, 16'hFFFF, C_NOP,      7, 0, 0, 0));
        vt.push_back(v(0, 1,  4, 1, 16'hFFFF, 16'hFFFF, C_NOP,      7, 0, 0, 0));
        vt.push_back(v(0, 1,  5, 1, 16'hFFFF, 16'hFFFF, C_NOP,      7, 0, 0, 0));
        vt.push_back(v(0, 1,  6, 1, 16'hFFFF, 16'hFFFF, C_NOP,      7, 0, 0, 0));
        vt.push_back(v(0, 1,  7, 1, 16'hFFFF, 16'hFFFF, C_NOP,      7, 0, 0, 0));
        vt.push_back(v(1, 1,  0, 1, 16'hFFFF, 16'hFFFF, C_NOP,      1, 0, 0, 0));
        vt.push_back(v(0, 1, 56, 1, 16'hFFFF, 16'hFFFF, C_NOP,      1, 0, 0, 0)); // bad order
        vt.push_back(v(0, 1,  2, 1, 16'hFFFF, 16'hFFFF, C_F2,       1, 0, 0, 1));
        vt.push_back(v(0, 1,  1, 1, 16'hFFFF, 16'hFFFF, C_F1,       1, 0, 0, 1)); // sticky
        vt.push_back(v(0, 1,  2, 1, 16'hFFFF, 16'hFFFF, C_F2,       1, 0, 0, 1));
        vt.push_back(v(0, 1,  3, 1, 16'h0002, 16'hFFFF, C_NOP,      2, 0, 0, 1));

        foreach (vt[i]) apply(vt[i]);

        // Random ALU steps from reset: z follows result==0, alu_op is the step offset.
        apply(v(1, 1, 0, 1, 16'hFFFF, 16'hFFFF, C_NOP, 1, 0, 0, 0));
        for (int i = 0; i < 24; i++) begin
            logic [5:0]  s;
            logic [15:0] a;
            logic [5:0]  off;
            s   = 6'($urandom_range(36, 51));
            a   = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
            off = s - 6'd36;
            apply(v(0, 1, s, 1, 16'hFFFF, a, c_alu(off[2:0]), 1, (a == 16'd0), 0, 0));
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d entries left", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
